uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_fifo.sv | 68 ++++++
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmitter: FSM state
//               encoding, parity mode constants, default baud divider and a
//               parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz system clock divided down to 38.4 kbaud
    localparam int DEFAULT_CLK_DIV = 1302;

    // Callers zero-extend narrower words; the extra zeros do not change the XOR
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : Synchronous first-word-fall-through FIFO with full, empty and
//               occupancy outputs. Writes while full are dropped even when a
//               read happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter fed by a small TX FIFO. Configurable baud
//               divider, data width, parity and stop bits. txd_out and busy
//               are registered and therefore trail the FSM state by one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [DATA_BITS-1:0]          data_in,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          txd_out,
    output logic                          busy
);

    localparam int               CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx_fifo: CLK_DIV must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, 2..64");
    end

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       baud_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_bit;
    logic                   bit_done;
    logic                   pop;
    logic                   txd_next;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   head;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (load),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign bit_done = (baud_cnt == BAUD_LAST);

    // Sticky record of any write attempted against a full FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (load && full) begin
            overflow <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, FIFO pop and line level for the current bit
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        txd_next   = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                txd_next = 1'b0;
                if (bit_done) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                txd_next = shift[0];
                if (bit_done && bit_cnt == DATA_LAST) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                end
            end
            ST_PAR: begin
                txd_next = par_bit;
                if (bit_done) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                txd_next = 1'b1;
                if (bit_done && bit_cnt == STOP_LAST) begin
                    // Chain straight into the next frame when data is waiting
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    // Baud/bit counters, shift register, parity latch and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            txd_out  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            txd_out <= txd_next;
            busy    <= (state != ST_IDLE) || !fifo_empty;

            if (state_next != state || bit_done || state == ST_IDLE) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            if (state_next != state) begin
                bit_cnt <= '0;
            end else if (bit_done) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (pop) begin
                shift   <= head;
                par_bit <= parity_bit(8'(head), PARITY);
            end else if (state == ST_DATA && bit_done) begin
                shift <= shift >> 1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. Three configurations
//               (8N1, 7E2, 8O1) run side by side against a queue-based line
//               model, plus directed frame, overflow and reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       ld  [3];
    logic [7:0] din [3];
    logic       txd_w  [3];
    logic       busy_w [3];
    logic       full_w [3];
    logic       ovf_w  [3];
    logic [2:0] lvl_w  [3];

    int cfg_cd  [3] = '{4, 4, 3};
    int cfg_db  [3] = '{8, 7, 8};
    int cfg_par [3] = '{0, 2, 1};
    int cfg_sb  [3] = '{1, 2, 1};

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .load(ld[0]), .data_in(din[0]), .full(full_w[0]),
        .level(lvl_w[0]), .overflow(ovf_w[0]), .txd_out(txd_w[0]), .busy(busy_w[0]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .load(ld[1]), .data_in(din[1][6:0]), .full(full_w[1]),
        .level(lvl_w[1]), .overflow(ovf_w[1]), .txd_out(txd_w[1]), .busy(busy_w[1]));
    uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .load(ld[2]), .data_in(din[2]), .full(full_w[2]),
        .level(lvl_w[2]), .overflow(ovf_w[2]), .txd_out(txd_w[2]), .busy(busy_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // q: accepted words; frm: line levels still to be driven for the frame in
    // flight, one entry per clock; the FSM output appears on txd one cycle late.
    int  q   [3][$];
    bit  frm [3][$];
    bit  fsm_out [3] = '{1, 1, 1};
    bit  fsm_act [3] = '{0, 0, 0};
    bit  e_txd  [3] = '{1, 1, 1};
    bit  e_busy [3] = '{0, 0, 0};
    bit  e_ovf  [3] = '{0, 0, 0};
    int  e_lvl  [3] = '{0, 0, 0};

    task automatic push_bit(input int i, input int v);
        for (int c = 0; c < cfg_cd[i]; c++) frm[i].push_back(v != 0);
    endtask

    task automatic build_frame(input int i, input int w);
        int ones;
        ones = 0;
        push_bit(i, 0);
        for (int b = 0; b < cfg_db[i]; b++) begin
            push_bit(i, (w >> b) & 1);
            ones += (w >> b) & 1;
        end
        if (cfg_par[i] == 2) push_bit(i, ones % 2);
        else if (cfg_par[i] == 1) push_bit(i, 1 - (ones % 2));
        for (int s = 0; s < cfg_sb[i]; s++) push_bit(i, 1);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                q[i].delete();
                frm[i].delete();
                fsm_out[i] = 1'b1;
                fsm_act[i] = 1'b0;
                e_txd[i]   = 1'b1;
                e_busy[i]  = 1'b0;
                e_ovf[i]   = 1'b0;
                e_lvl[i]   = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit pop_now;
                bit wr_now;
                e_txd[i]  = fsm_out[i];
                e_busy[i] = fsm_act[i] || (q[i].size() > 0);
                pop_now   = (frm[i].size() == 0) && (q[i].size() > 0);
                wr_now    = ld[i] && (q[i].size() < 4);
                if (ld[i] && q[i].size() == 4) e_ovf[i] = 1'b1;
                if (pop_now) build_frame(i, q[i].pop_front());
                if (wr_now) q[i].push_back(int'(din[i]) & ((1 << cfg_db[i]) - 1));
                if (frm[i].size() > 0) begin
                    fsm_out[i] = frm[i].pop_front();
                    fsm_act[i] = 1'b1;
                end else begin
                    fsm_out[i] = 1'b1;
                    fsm_act[i] = 1'b0;
                end
                e_lvl[i] = q[i].size();
            end
        end
    end

    // Compare every DUT output against the model on each falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("txd[%0d]", i),   int'(txd_w[i]),  int'(e_txd[i]));
            chk($sformatf("busy[%0d]", i),  int'(busy_w[i]), int'(e_busy[i]));
            chk($sformatf("level[%0d]", i), int'(lvl_w[i]),  e_lvl[i]);
            chk($sformatf("full[%0d]", i),  int'(full_w[i]), int'(e_lvl[i] == 4));
            chk($sformatf("ovf[%0d]", i),   int'(ovf_w[i]),  int'(e_ovf[i]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    bit capt [3][50];
    bit capb [3][50];
    int exp_a [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int exp_b [11] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1};

    task automatic capture;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                capt[i][k] = txd_w[i];
                capb[i][k] = busy_w[i];
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1;
        for (int i = 0; i < 3; i++) begin
            ld[i]  = 1'b0;
            din[i] = 8'h00;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset_txd",   int'(txd_w[0]),  1);
        chk("reset_busy",  int'(busy_w[0]), 0);
        chk("reset_level", int'(lvl_w[0]),  0);
        chk("reset_full",  int'(full_w[0]), 0);
        chk("reset_ovf",   int'(ovf_w[0]),  0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        tick();

        // Single frames: 0x55 8N1, 0x41 7E2, 0x00 8O1 loaded at the same edge
        ld[0] = 1'b1; din[0] = 8'h55;
        ld[1] = 1'b1; din[1] = 8'h41;
        ld[2] = 1'b1; din[2] = 8'h00;
        tick();
        for (int i = 0; i < 3; i++) ld[i] = 1'b0;
        capture();
        chk("a_latency_e1", int'(capt[0][1]), 1);
        chk("a_latency_e2", int'(capt[0][2]), 0);
        for (int j = 0; j < 10; j++) chk($sformatf("a_bit%0d", j), int'(capt[0][2 + j*4 + 1]), exp_a[j]);
        chk("a_busy_last_stop", int'(capb[0][41]), 1);
        chk("a_busy_after",     int'(capb[0][42]), 0);
        chk("a_line_after",     int'(capt[0][43]), 1);
        for (int j = 0; j < 11; j++) chk($sformatf("b_bit%0d", j), int'(capt[1][2 + j*4 + 1]), exp_b[j]);
        chk("b_line_after", int'(capt[1][46]), 1);
        chk("b_busy_after", int'(capb[1][46]), 0);
        chk("c_parity_00",  int'(capt[2][2 + 9*3 + 1]), 1);

        tick();
        ld[2] = 1'b1; din[2] = 8'h01;
        tick();
        ld[2] = 1'b0;
        capture();
        chk("c_data0_01",   int'(capt[2][2 + 1*3 + 1]), 1);
        chk("c_parity_01",  int'(capt[2][2 + 9*3 + 1]), 0);

        // Back-to-back loads into the 4-deep FIFO, then one too many
        tick();
        ld[0] = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            din[0] = 8'(8'h30 + n);
            tick();
            if (n == 1) e1 = cyc;
            if (n == 5) begin
                chk("burst_full",  int'(full_w[0]), 1);
                chk("burst_level", int'(lvl_w[0]),  4);
                chk("burst_ovf0",  int'(ovf_w[0]),  0);
            end
        end
        ld[0] = 1'b0;
        chk("burst_ovf1",   int'(ovf_w[0]), 1);
        chk("burst_level6", int'(lvl_w[0]), 4);
        while (busy_w[0] && (cyc - e1) < 400) tick();
        chk("burst_drain_cycles", cyc - e1, 202);

        // Reset during data bit 3 with words still queued
        tick();
        ld[0] = 1'b1; din[0] = 8'h55;
        tick(); tick(); tick();
        ld[0] = 1'b0;
        chk("pre_rst_level", int'(lvl_w[0]), 2);
        repeat (17) tick();
        chk("pre_rst_txd", int'(txd_w[0]), 0);
        #3 rst = 1'b0;
        #1;
        chk("rst_txd",   int'(txd_w[0]),  1);
        chk("rst_level", int'(lvl_w[0]),  0);
        chk("rst_busy",  int'(busy_w[0]), 0);
        chk("rst_full",  int'(full_w[0]), 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        ld[0] = 1'b1; din[0] = 8'hA5;
        tick();
        ld[0] = 1'b0;
        chk("post_rst_level", int'(lvl_w[0]), 1);
        chk("post_rst_e1",    int'(txd_w[0]), 1);
        tick();
        chk("post_rst_e1b",   int'(txd_w[0]), 1);
        tick();
        chk("post_rst_e2",    int'(txd_w[0]), 0);

        // Randomised traffic at three load densities, with one reset midway
        for (int ph = 0; ph < 3; ph++) begin
            int pct;
            pct = (ph == 0) ? 5 : (ph == 1) ? 30 : 90;
            for (int c = 0; c < 1000; c++) begin
                for (int i = 0; i < 3; i++) begin
                    ld[i]  = ($urandom_range(0, 99) < pct);
                    din[i] = 8'($urandom);
                end
                tick();
                if (ph == 1 && c == 500) begin
                    #3 rst = 1'b0;
                    @(posedge clk);
                    #2 rst = 1'b1;
                end
            end
        end
        for (int i = 0; i < 3; i++) ld[i] = 1'b0;
        repeat (400) tick();
        chk("final_idle_a", int'(busy_w[0]), 0);
        chk("final_idle_b", int'(busy_w[1]), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
